// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Provides the FSM state encoding, the status-flag payload and the
// byte/word geometry used by the loader and its word packer.
package imem_boot_pkg;

    localparam int unsigned LEN_W  = 16;               // header length field width
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = WORD_W / BYTE_W;  // bytes per word
    localparam logic [1:0]  LANE_LAST = 2'(LANES - 1); // lane that completes a word

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        DONE,
        ERR
    } boot_state_t;

    // Status flags presented to the core / host, one set per state.
    typedef struct packed {
        logic cpu_rst;
        logic busy;
        logic done;
        logic err;
    } boot_status_t;

    // Status flags belonging to a state; registered alongside the state.
    function automatic boot_status_t status_of(input boot_state_t s);
        boot_status_t st;
        st.cpu_rst = (s != DONE);
        st.busy    = (s == HDR0) || (s == HDR1) || (s == DATA);
        st.done    = (s == DONE);
        st.err     = (s == ERR);
        return st;
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_clear        restart packing at byte lane 0
//   i_byte_en      i_byte_in is consumed this cycle
//   i_byte_in      stream byte
//   o_word_valid   high in the cycle the 4th byte of a word is consumed
//   o_word_out     assembled word, valid with o_word_valid
module imem_word_packer
    import imem_boot_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_byte_en,
    input  logic [BYTE_W-1:0] i_byte_in,
    output logic              o_word_valid,
    output logic [WORD_W-1:0] o_word_out
);

    logic [1:0]               r_byte_idx;
    logic [WORD_W-BYTE_W-1:0] r_lanes;    // lanes 0..2; lane 3 comes straight from i_byte_in

    // Lane capture; byte index wraps 3 -> 0 naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_byte_idx <= 2'd0;
            r_lanes    <= '0;
        end else if (i_byte_en) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
                2'd0:    r_lanes[0*BYTE_W +: BYTE_W] <= i_byte_in;
                2'd1:    r_lanes[1*BYTE_W +: BYTE_W] <= i_byte_in;
                2'd2:    r_lanes[2*BYTE_W +: BYTE_W] <= i_byte_in;
                default: ;
            endcase
        end
    end

    // Word completes combinationally so the loader can register the write next cycle.
    assign o_word_valid = i_byte_en && (r_byte_idx == LANE_LAST);
    assign o_word_out   = {i_byte_in, r_lanes};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed little-endian byte stream, packs it
// into words and writes them sequentially into instruction memory, holding the
// core in reset until a complete image has landed.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_start                begin a new load (honoured in IDLE/DONE/ERR)
//   i_in_valid, i_in_data  byte stream in; o_in_ready accepts it
//   o_imem_we/waddr/wdata  instruction-memory write port (1-cycle strobe per word)
//   o_cpu_rst              core reset, low only once an image is complete
//   o_busy, o_done, o_err  loader status
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_in_valid,
    input  logic [BYTE_W-1:0] i_in_data,
    output logic              o_in_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_waddr,
    output logic [WORD_W-1:0] o_imem_wdata,
    output logic              o_cpu_rst,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int unsigned CAPACITY = 2**ADDR_W;

    boot_state_t       r_state;
    boot_status_t      r_status;
    logic              r_in_ready;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_waddr;
    logic [WORD_W-1:0] r_imem_wdata;
    logic [LEN_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_word_idx;

    logic              w_xfer;
    logic              w_byte_en;
    logic              w_pack_clear;
    logic              w_word_valid;
    logic [WORD_W-1:0] w_word;
    logic [LEN_W-1:0]  w_hdr_len;
    logic              w_too_long;
    logic              w_last_word;

    assign w_xfer       = i_in_valid && r_in_ready;
    assign w_byte_en    = w_xfer && (r_state == DATA);
    assign w_pack_clear = w_xfer && (r_state == HDR1);

    // Full length as it will be once the high header byte lands.
    assign w_hdr_len   = {i_in_data, r_cnt[BYTE_W-1:0]};
    assign w_too_long  = 32'(w_hdr_len) > CAPACITY;
    assign w_last_word = (LEN_W'(r_word_idx) == (r_cnt - LEN_W'(1)));

    imem_word_packer u_packer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (w_pack_clear),
        .i_byte_en    (w_byte_en),
        .i_byte_in    (i_in_data),
        .o_word_valid (w_word_valid),
        .o_word_out   (w_word)
    );

    // Loader FSM; status flags and in_ready are registered together with the state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_status     <= status_of(IDLE);
            r_in_ready   <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_waddr <= '0;
            r_imem_wdata <= '0;
            r_cnt        <= '0;
            r_word_idx   <= '0;
        end else begin
            r_imem_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state    <= HDR0;
                        r_status   <= status_of(HDR0);
                        r_in_ready <= 1'b1;
                    end
                end
                HDR0: begin
                    if (w_xfer) begin
                        r_cnt[BYTE_W-1:0] <= i_in_data;
                        r_state           <= HDR1;
                        r_status          <= status_of(HDR1);
                    end
                end
                HDR1: begin
                    if (w_xfer) begin
                        r_cnt <= w_hdr_len;
                        if (w_hdr_len == '0) begin
                            r_state    <= DONE;
                            r_status   <= status_of(DONE);
                            r_in_ready <= 1'b0;
                        end else if (w_too_long) begin
                            r_state    <= ERR;
                            r_status   <= status_of(ERR);
                            r_in_ready <= 1'b0;
                        end else begin
                            r_state    <= DATA;
                            r_status   <= status_of(DATA);
                            r_word_idx <= '0;
                        end
                    end
                end
                DATA: begin
                    if (r_imem_we) begin
                        // Write cycle: either finish or reopen the byte port.
                        // word_idx is left alone after the last word so it never wraps.
                        if (w_last_word) begin
                            r_state  <= DONE;
                            r_status <= status_of(DONE);
                        end else begin
                            r_word_idx <= r_word_idx + ADDR_W'(1);
                            r_in_ready <= 1'b1;
                        end
                    end else if (w_word_valid) begin
                        r_imem_we    <= 1'b1;
                        r_imem_waddr <= r_word_idx;
                        r_imem_wdata <= w_word;
                        r_in_ready   <= 1'b0;
                    end
                end
                DONE, ERR: begin
                    if (i_start) begin
                        r_state    <= HDR0;
                        r_status   <= status_of(HDR0);
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_status   <= status_of(IDLE);
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_imem_we    = r_imem_we;
    assign o_imem_waddr = r_imem_waddr;
    assign o_imem_wdata = r_imem_wdata;
    assign o_cpu_rst    = r_status.cpu_rst;
    assign o_busy       = r_status.busy;
    assign o_done       = r_status.done;
    assign o_err        = r_status.err;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed boot scenarios plus
// randomized images, checked against an image-level model of the stream format.
module tb_imem_boot_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CAP    = 2**ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_in_valid   (in_valid),
        .i_in_data    (in_data),
        .o_in_ready   (in_ready),
        .o_imem_we    (imem_we),
        .o_imem_waddr (imem_waddr),
        .o_imem_wdata (imem_wdata),
        .o_cpu_rst    (cpu_rst),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus stream and expected image
    logic [7:0]  stim_q[$];
    int unsigned exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    bit          exp_err;

    // Observed writes and events
    int unsigned wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    bit          done_seen;
    int          done_cyc;
    int          viol;
    bit          drv_timeout;
    bit          end_timeout;
    int          last_xfer_cyc;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(int'(imem_waddr));
            wr_data_q.push_back(imem_wdata);
            wr_cyc_q.push_back(cyc);
        end
        if (imem_we && in_ready) viol++;
        if (done && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
    end

    // Image-level model: length header, then len little-endian words.
    task automatic build_expect();
        int unsigned len;
        exp_addr_q.delete();
        exp_data_q.delete();
        len = int'(stim_q[0]) | (int'(stim_q[1]) << 8);
        exp_err = (len > CAP);
        if (!exp_err) begin
            for (int unsigned i = 0; i < len; i++) begin
                exp_addr_q.push_back(i);
                exp_data_q.push_back({stim_q[2+4*i+3], stim_q[2+4*i+2],
                                      stim_q[2+4*i+1], stim_q[2+4*i]});
            end
        end
    endtask

    task automatic clear_obs();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_seen   = 1'b0;
        viol        = 0;
        drv_timeout = 1'b0;
        end_timeout = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_seen = 1'b0;
    endtask

    // Sends stim_q; gaps of min..max idle cycles before each byte. With hold set,
    // the first byte of each new word follows without a gap so in_valid stays
    // high through the write cycle.
    task automatic send_bytes(input int min_gap, input int max_gap, input bit hold);
        int gap;
        int w;
        bit rdy;
        for (int k = 0; k < stim_q.size(); k++) begin
            if (drv_timeout) break;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, min_gap)) : 0;
            if (hold && k >= 6 && ((k - 2) % 4) == 0) gap = 0;
            in_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_data  = stim_q[k];
            rdy = 1'b0;
            w   = 0;
            while (!rdy && w < 20) begin
                @(negedge clk);
                rdy = in_ready;
                last_xfer_cyc = cyc;
                @(posedge clk); #1;
                w++;
            end
            if (!rdy) drv_timeout = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_end();
        int w;
        w = 0;
        while (w < 60) begin
            @(negedge clk);
            if (done || err) break;
            w++;
        end
        if (w >= 60) end_timeout = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic load(input int min_gap, input int max_gap, input bit hold);
        build_expect();
        pulse_start();
        clear_obs();
        send_bytes(min_gap, max_gap, hold);
        wait_end();
    endtask

    task automatic set_t1();
        stim_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                   8'h13, 8'h01, 8'hA0, 8'h00};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({cpu_rst, busy, done, err, in_ready, imem_we} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags got=%b want=100000", {cpu_rst, busy, done, err, in_ready, imem_we});
        end
        checks++;
        if (imem_waddr !== '0 || imem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_wport got addr=%0h data=%08h want 0/0", imem_waddr, imem_wdata);
        end
    endtask

    task automatic test_basic();
        set_t1();
        load(0, 0, 1'b0);
        checks++;
        if (drv_timeout || end_timeout || wr_addr_q.size() != 2) begin
            errors++;
            $display("FAIL t1_writes got=%0d timeout=%0d/%0d want=2", wr_addr_q.size(), drv_timeout, end_timeout);
        end
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
                errors++;
                $display("FAIL t1_word%0d got=%0d:%08h want=%0d:%08h", i, wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
            end
        end
        checks++;
        if (!done_seen || wr_cyc_q.size() != 2 || done_cyc != wr_cyc_q[1] + 1) begin
            errors++;
            $display("FAIL t1_done_timing got seen=%0d cyc=%0d want one after last write", done_seen, done_cyc);
        end
        checks++;
        if ({done, cpu_rst, busy, err, in_ready} !== 5'b10000) begin
            errors++;
            $display("FAIL t1_final got=%b want=10000", {done, cpu_rst, busy, err, in_ready});
        end
    endtask

    task automatic test_empty();
        stim_q = '{8'h00, 8'h00};
        load(0, 0, 1'b0);
        checks++;
        if (wr_addr_q.size() != 0) begin
            errors++;
            $display("FAIL t2_nowrite got=%0d want=0", wr_addr_q.size());
        end
        checks++;
        if (!done_seen || done_cyc != last_xfer_cyc + 1 || cpu_rst !== 1'b0) begin
            errors++;
            $display("FAIL t2_done got seen=%0d cyc=%0d cpu_rst=%b want cyc=%0d cpu_rst=0", done_seen, done_cyc, cpu_rst, last_xfer_cyc + 1);
        end
    endtask

    task automatic test_overflow();
        stim_q = '{8'h01, 8'h01};
        load(0, 0, 1'b0);
        checks++;
        if ({err, cpu_rst, in_ready, done, busy} !== 5'b11000 || wr_addr_q.size() != 0) begin
            errors++;
            $display("FAIL t3_err got=%b writes=%0d want=11000 writes=0", {err, cpu_rst, in_ready, done, busy}, wr_addr_q.size());
        end
        set_t1();
        load(0, 0, 1'b0);
        checks++;
        if (wr_addr_q.size() != 2 || !done || err) begin
            errors++;
            $display("FAIL t3_recover got writes=%0d done=%b err=%b want 2/1/0", wr_addr_q.size(), done, err);
        end
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
                errors++;
                $display("FAIL t3_word%0d got=%0d:%08h want=%0d:%08h", i, wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
            end
        end
    endtask

    task automatic test_gaps();
        set_t1();
        load(1, 5, 1'b1);
        checks++;
        if (drv_timeout || end_timeout || wr_addr_q.size() != 2 || viol != 0) begin
            errors++;
            $display("FAIL t4_gaps got writes=%0d ready_in_we=%0d want writes=2 ready_in_we=0", wr_addr_q.size(), viol);
        end
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
                errors++;
                $display("FAIL t4_word%0d got=%0d:%08h want=%0d:%08h", i, wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_t1();
        build_expect();
        pulse_start();
        clear_obs();
        stim_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13};
        send_bytes(0, 0, 1'b0);
        wr_addr_q.delete();
        wr_data_q.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({busy, cpu_rst, in_ready, done, err} !== 5'b01000) begin
            errors++;
            $display("FAIL t5_idle got=%b want=01000", {busy, cpu_rst, in_ready, done, err});
        end
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (10) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (wr_addr_q.size() != 0 || busy !== 1'b0 || cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL t5_quiet got writes=%0d busy=%b cpu_rst=%b want 0/0/1", wr_addr_q.size(), busy, cpu_rst);
        end
        set_t1();
        load(0, 2, 1'b0);
        checks++;
        if (wr_addr_q.size() != 2 || !done) begin
            errors++;
            $display("FAIL t5_rerun got writes=%0d done=%b want 2/1", wr_addr_q.size(), done);
        end
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
                errors++;
                $display("FAIL t5_word%0d got=%0d:%08h want=%0d:%08h", i, wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        set_t1();
        build_expect();
        pulse_start();
        clear_obs();
        stim_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50};
        send_bytes(0, 0, 1'b0);
        pulse_start();
        checks++;
        if (busy !== 1'b1 || cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL t6_start_busy got busy=%b cpu_rst=%b want 1/1", busy, cpu_rst);
        end
        stim_q = '{8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
        send_bytes(0, 0, 1'b0);
        wait_end();
        checks++;
        if (wr_addr_q.size() != 2 || !done || end_timeout) begin
            errors++;
            $display("FAIL t6_load got writes=%0d done=%b want 2/1", wr_addr_q.size(), done);
        end
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
                errors++;
                $display("FAIL t6_word%0d got=%0d:%08h want=%0d:%08h", i, wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
            end
        end
        pulse_start();
        checks++;
        if ({cpu_rst, busy, done} !== 3'b110) begin
            errors++;
            $display("FAIL t6_restart got=%b want=110", {cpu_rst, busy, done});
        end
        stim_q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        build_expect();
        clear_obs();
        send_bytes(0, 0, 1'b0);
        wait_end();
        checks++;
        if (wr_addr_q.size() != 1 || !done || cpu_rst) begin
            errors++;
            $display("FAIL t6_one_word got writes=%0d done=%b cpu_rst=%b want 1/1/0", wr_addr_q.size(), done, cpu_rst);
        end else begin
            checks++;
            if (wr_addr_q[0] !== 0 || wr_data_q[0] !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL t6_word0 got=%0d:%08h want=0:deadbeef", wr_addr_q[0], wr_data_q[0]);
            end
        end
    endtask

    // Random images: full capacity, an oversize header, and short random lengths.
    task automatic test_random();
        int unsigned len;
        for (int it = 0; it < 6; it++) begin
            if (it == 0)      len = CAP;
            else if (it == 1) len = $urandom_range(2000, CAP + 1);
            else              len = $urandom_range(12, 1);
            stim_q.delete();
            stim_q.push_back(8'(len));
            stim_q.push_back(8'(len >> 8));
            if (len <= CAP)
                for (int unsigned b = 0; b < 4 * len; b++) stim_q.push_back(8'($urandom));
            load(0, (it == 0) ? 1 : 3, 1'($urandom));
            checks++;
            if (drv_timeout || end_timeout || wr_addr_q.size() != exp_addr_q.size()
                || done !== !exp_err || err !== exp_err || cpu_rst !== exp_err || viol != 0) begin
                errors++;
                $display("FAIL rnd%0d_len%0d got writes=%0d done=%b err=%b cpu_rst=%b want writes=%0d err=%b",
                         it, len, wr_addr_q.size(), done, err, cpu_rst, exp_addr_q.size(), exp_err);
            end
            for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
                checks++;
                if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
                    errors++;
                    $display("FAIL rnd%0d_word%0d got=%0d:%08h want=%0d:%08h", it, i, wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_overflow();
        test_gaps();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
